// File: rtl/router_pkt_framer.sv
// router_pkt_framer: upstream packet source for the 1x3 router.
// Takes a request (destination address + payload length), buffers the whole payload from a
// valid/ready byte stream, then emits header, payload and parity to the router as one
// contiguous burst, honouring the router's busy back-pressure.
//
// Ports:
//   clock, reset              - clock; asynchronous active-high reset
//   req_valid/addr/len        - packet request; req_ready high only in IDLE
//   pl_valid/pl_data          - payload byte stream; pl_ready high only in COLLECT
//   rtr_busy                  - router back-pressure
//   rtr_data, rtr_pkt_valid   - registered byte and packet-valid to the router
//   pkt_done, req_err         - one-cycle pulses (parity accepted / request rejected)
//   pkt_count                 - packets sent, wraps at 255
module router_pkt_framer #(
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    output logic       req_ready,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       rtr_busy,
    output logic [7:0] rtr_data,
    output logic       rtr_pkt_valid,
    output logic       pkt_done,
    output logic       req_err,
    output logic [7:0] pkt_count
);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StHeader,
        StPayload,
        StParity,
        StGap
    } state_e;

    localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] par_q, par_d;
    logic [5:0] wr_q, wr_d;
    logic [5:0] rd_q, rd_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] count_q, count_d;
    logic       buf_we;
    logic [5:0] len;

    logic [7:0] pkt_buf [MAX_LEN];

    assign len = hdr_q[7:2];

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        par_d   = par_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        buf_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_len == 6'd0 || req_addr == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        hdr_d   = {req_len, req_addr};
                        par_d   = {req_len, req_addr};
                        wr_d    = 6'd0;
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (pl_valid) begin
                    buf_we = 1'b1;
                    par_d  = par_q ^ pl_data;
                    wr_d   = wr_q + 6'd1;
                    // Last beat: present the header on the very next cycle.
                    if (wr_q + 6'd1 == len) begin
                        data_d  = hdr_q;
                        valid_d = 1'b1;
                        state_d = StHeader;
                    end
                end
            end
            StHeader: begin
                if (!rtr_busy) begin
                    data_d  = pkt_buf[0];
                    rd_d    = 6'd1;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (!rtr_busy) begin
                    // rd_q points one past the byte on rtr_data.
                    if (rd_q == len) begin
                        data_d  = par_q;
                        valid_d = 1'b0;
                        state_d = StParity;
                    end else begin
                        data_d = pkt_buf[rd_q];
                        rd_d   = rd_q + 6'd1;
                    end
                end
            end
            StParity: begin
                if (!rtr_busy) begin
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    data_d  = 8'd0;
                    gap_d   = 8'd0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hdr_q   <= 8'd0;
            par_q   <= 8'd0;
            wr_q    <= 6'd0;
            rd_q    <= 6'd0;
            gap_q   <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            par_q   <= par_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; it is always written before being read.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            pkt_buf[wr_q] <= pl_data;
        end
    end

    assign req_ready     = (state_q == StIdle);
    assign pl_ready      = (state_q == StCollect);
    assign rtr_data      = data_q;
    assign rtr_pkt_valid = valid_q;
    assign pkt_done      = done_q;
    assign req_err       = err_q;
    assign pkt_count     = count_q;

endmodule

// File: doc/router_pkt_framer.md
# router_pkt_framer

Upstream packet source for the 1x3 router. It accepts a packet request (destination address and payload length), then buffers that many payload bytes from a valid/ready byte stream. Once the packet is complete, it drives the router input as one contiguous burst: header, payload, then parity. It honours the router's `busy` back-pressure. Full buffering guarantees the router never sees a bubble inside a packet.

## Interface

- `MAX_LEN`, 63: largest payload length. Sets buffer depth; must fit in 6 bits.
- `GAP_CYCLES`, 2: minimum idle cycles with `rtr_pkt_valid` low between the parity byte and the next header.

Ports:

- `clock`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req_valid`  in  1  packet request present.
- `req_addr`  in  2  destination port, 0..2.
- `req_len`  in  6  payload length, 1..MAX_LEN.
- `req_ready`  out  1  high exactly when in IDLE.
- `pl_valid`  in  1  payload byte present.
- `pl_data`  in  8  payload byte.
- `pl_ready`  out  1  high exactly when in COLLECT.
- `rtr_busy`  in  1  router back-pressure.
- `rtr_data`  out  8  byte to the router `data_in`.
- `rtr_pkt_valid`  out  1  to the router `pkt_valid`.
- `pkt_done`  out  1  one-cycle pulse when the parity byte is accepted.
- `req_err`  out  1  one-cycle pulse when a request is rejected.
- `pkt_count`  out  8  count of packets sent; wraps 255→0.

## Operation

States: IDLE, COLLECT, HEADER, PAYLOAD, PARITY, GAP.

- **IDLE:** on `req_valid`, the request is always consumed.
  - If `req_len`==0 or `req_addr`==3: pulse `req_err` on the next cycle and stay in IDLE.
  - Otherwise latch `hdr={req_len,req_addr}`, set `par=hdr`, clear the write index, and go to COLLECT.
- **COLLECT:** each `pl_valid`&`pl_ready` beat writes `buf[wr]=pl_data`, sets `par^=pl_data`, and increments `wr`.
  - When `wr` reaches len, go to HEADER, loading `rtr_data=hdr` and `rtr_pkt_valid=1`.
- **Transfer rule:** a byte on `rtr_data` transfers at a rising edge where `rtr_busy`=0.
  - While `rtr_busy`=1, `rtr_data`, `rtr_pkt_valid` and the state hold unchanged.
- **HEADER:** on transfer, load `buf[0]` and go to PAYLOAD.
- **PAYLOAD:** on each transfer, advance the read index.
  - After the transfer of `buf[len-1]`, load `rtr_data=par` and `rtr_pkt_valid=0`, then go to PARITY.
- **PARITY:** on transfer:
  - pulse `pkt_done`;
  - increment `pkt_count`;
  - set `rtr_data` to 0;
  - go to GAP.
- **GAP:** hold `rtr_pkt_valid=0` for `GAP_CYCLES` cycles, then return to IDLE. `rtr_busy` is ignored.
- **Parity arithmetic:** 8-bit XOR of the header and all payload bytes, computed during COLLECT.
- Read and write indices are 6-bit. The buffer is not reused until the packet fully drains.

## Timing

- **Reset values:**
  - `rtr_data`=0, `rtr_pkt_valid`=0, `pl_ready`=0;
  - `pkt_done`=0, `req_err`=0, `pkt_count`=0;
  - `req_ready`=1 (state is IDLE).
- **Registered outputs:** `rtr_data`, `rtr_pkt_valid`, `pkt_done`, `req_err` and `pkt_count`. `req_ready` and `pl_ready` are decoded from state.
- **Request to collect:** a request accepted at edge T0 gives `pl_ready`=1 from T0+.
- **Collect to header:** when the last payload beat is taken at edge Tc, the header is visible after Tc.
- **Burst length:** with `rtr_busy`=0 throughout:
  - `rtr_pkt_valid` is high for len+1 cycles (header plus payload);
  - the parity byte follows for 1 cycle;
  - then `GAP_CYCLES` idle cycles;
  - IDLE (`req_ready`=1) resumes len+2+`GAP_CYCLES` cycles after Tc.
- **Mid-packet stability:** during HEADER, PAYLOAD and PARITY, `rtr_data` changes only at transfer edges. `pl_valid` has no effect outside COLLECT.
- **Reset mid-operation:** all outputs return to reset values asynchronously, and the partial packet is discarded. After release, the next request is processed normally.

## Test plan

- **Basic packet:** len=10, addr=0, `rtr_busy`=0, payload fed one byte per cycle.
  - `rtr_data` shows 0x28, then the 10 bytes in order, then their XOR with 0x28 while `rtr_pkt_valid`=0.
  - `rtr_pkt_valid` is high exactly 11 cycles; `pkt_done` pulses once; `pkt_count`=1.
- **Back-pressure:** len=14, addr=1, `rtr_busy`=1 for 3 cycles during the header and 2 cycles during payload byte 5.
  - The header is held for 4 cycles and byte 5 for 3 cycles.
  - No bytes are dropped or duplicated, and parity is correct.
- **Sparse payload:** `pl_valid` toggles with random gaps during COLLECT.
  - `rtr_pkt_valid` stays 0 until all bytes are buffered.
  - The router-side burst is contiguous.
- **Rejected requests:** send len=0, then addr=3.
  - Each produces one `req_err` pulse, no `rtr_pkt_valid`, and `pkt_count` unchanged.
- **Maximum length and back-to-back:** len=63, addr=2 (header 0xFE), immediately followed by len=18, addr=2.
  - 63 payload bytes are sent, followed by at least 2 idle cycles before the second header 0x4A.
  - `pkt_count`=2.
- **Reset mid-packet:** assert `reset` during PAYLOAD.
  - `rtr_pkt_valid` goes 0 immediately and `req_ready`=1 after release.
  - A fresh len=10 packet then transmits correctly.
